mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//
// Multi-cycle multiply/divide unit with architectural HI/LO registers for a
// MIPS-style pipeline. The product or quotient/remainder is worked out
// combinationally from the E-stage operands when the op is accepted. It is then
// held in a pending register while a down-counter models the unit's latency.
// The pending value is copied into HI/LO only when the counter expires.
//
// Ports
//   clk         : clock; every state change happens on its rising edge
//   reset       : asynchronous, active-high; clears HI, LO, pending and counter
//   XALUOp_E    : E-stage op code
//                 000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU,
//                 101 MTHI, 110 MTLO, 111 NOP
//   XALU_Src_E  : read select for XALU_Out (1 = HI, 0 = LO)
//   A_E         : rs operand (multiplicand / dividend / MTHI-MTLO data)
//   B_E         : rt operand (multiplier / divisor)
//   XALU_Start  : a multiply/divide is accepted at the coming edge
//   XALU_Busy   : an accepted operation has not yet committed to HI/LO
//   XALU_Out    : committed HI or LO value (MFHI/MFLO data)
//
// Start/busy handshake: XALU_Start is high when XALUOp_E is a MULT/MULTU/
// DIV/DIVU code and XALU_Busy is low. The op is taken at the edge where
// XALU_Start is high. XALU_Busy then stays high for exactly the configured
// cycle count. The result lands in HI/LO on the edge that lowers XALU_Busy.
// While busy, every op (including MTHI/MTLO) is ignored and nothing is queued.
// The upstream hazard unit stalls instead.
// -----------------------------------------------------------------------------
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  XALUOp_E,
  input  logic        XALU_Src_E,
  input  logic [31:0] A_E,
  input  logic [31:0] B_E,
  output logic        XALU_Start,
  output logic        XALU_Busy,
  output logic [31:0] XALU_Out
);

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_MULT  = 3'b001,
    OP_MULTU = 3'b010,
    OP_DIV   = 3'b011,
    OP_DIVU  = 3'b100,
    OP_MTHI  = 3'b101,
    OP_MTLO  = 3'b110,
    OP_NOP7  = 3'b111
  } op_e;

  // The counter is wide enough for the larger latency, and never narrower than 1 bit.
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  // Architectural and in-flight state
  logic [31:0]   hi;
  logic [31:0]   lo;
  logic [63:0]   pend;      // {HI, LO} waiting for commit
  logic          pend_we;   // cleared for a divide by zero, so HI/LO are kept
  logic [CW-1:0] count;     // remaining busy cycles; 0 means idle

  // Op decode
  logic is_mult;
  logic is_div;
  logic is_signed_div;

  always_comb begin
    is_mult       = 1'b0;
    is_div        = 1'b0;
    is_signed_div = 1'b0;
    case (op_e'(XALUOp_E))
      OP_MULT, OP_MULTU: is_mult = 1'b1;
      OP_DIV:            begin is_div = 1'b1; is_signed_div = 1'b1; end
      OP_DIVU:           is_div = 1'b1;
      default:           ;
    endcase
  end

  assign XALU_Busy  = (count != '0);
  assign XALU_Start = (is_mult | is_div) & ~XALU_Busy;

  // Multiply: sign- or zero-extend both operands to 64 bits. The low 64 bits
  // of the product are then the exact result in both cases.
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] product;

  always_comb begin
    if (op_e'(XALUOp_E) == OP_MULT) begin
      a_ext = {{32{A_E[31]}}, A_E};
      b_ext = {{32{B_E[31]}}, B_E};
    end else begin
      a_ext = {32'b0, A_E};
      b_ext = {32'b0, B_E};
    end
    product = a_ext * b_ext;
  end

  // Divide: an unsigned divider works on magnitudes and the signs are applied
  // afterwards. The quotient is negated when the operand signs differ, giving
  // truncation toward zero. The remainder follows the dividend's sign.
  // 0x80000000 / -1 gives an unsigned quotient of 0x80000000. Negating that
  // wraps back to 0x80000000, with remainder 0, which is the defined result.
  logic        a_neg;
  logic        b_neg;
  logic        div_zero;
  logic [31:0] dividend_mag;
  logic [31:0] divisor_mag;
  logic [31:0] uquot;
  logic [31:0] urem;
  logic [31:0] quot;
  logic [31:0] rem;

  always_comb begin
    a_neg        = is_signed_div & A_E[31];
    b_neg        = is_signed_div & B_E[31];
    div_zero     = (B_E == 32'd0);
    dividend_mag = a_neg ? (32'd0 - A_E) : A_E;
    divisor_mag  = b_neg ? (32'd0 - B_E) : B_E;
    // The divisor-zero case is discarded by pend_we. Forcing zeros here keeps
    // the divider output defined in that case.
    if (div_zero) begin
      uquot = 32'd0;
      urem  = 32'd0;
    end else begin
      uquot = dividend_mag / divisor_mag;
      urem  = dividend_mag % divisor_mag;
    end
    quot = (a_neg ^ b_neg) ? (32'd0 - uquot) : uquot;
    rem  = a_neg ? (32'd0 - urem) : urem;
  end

  // Result selected for the accepted op
  logic [63:0]   result;
  logic          result_we;
  logic [CW-1:0] load;

  always_comb begin
    if (is_mult) begin
      result    = product;
      result_we = 1'b1;
      load      = MULT_LOAD;
    end else begin
      result    = {rem, quot};
      result_we = ~div_zero;
      load      = DIV_LOAD;
    end
  end

  // State update. A start and an expiring count never share an edge, because
  // starting requires Busy=0. MTHI/MTLO only take effect when idle, so they
  // never race a commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend    <= 64'd0;
      pend_we <= 1'b0;
      count   <= '0;
    end else if (XALU_Start) begin
      if (load == '0) begin
        // A latency of zero commits straight away and never raises Busy.
        if (result_we) begin
          hi <= result[63:32];
          lo <= result[31:0];
        end
      end else begin
        pend    <= result;
        pend_we <= result_we;
        count   <= load;
      end
    end else if (XALU_Busy) begin
      count <= count - CNT_ONE;
      if (count == CNT_ONE && pend_we) begin
        hi <= pend[63:32];
        lo <= pend[31:0];
      end
    end else if (op_e'(XALUOp_E) == OP_MTHI) begin
      hi <= A_E;
    end else if (op_e'(XALUOp_E) == OP_MTLO) begin
      lo <= A_E;
    end
  end

  // Reads see only the committed registers, never the pending result.
  assign XALU_Out = XALU_Src_E ? hi : lo;

endmodule
